// File: rtl/mem_responder.sv
// mem_responder: word memory answering controller requests with a one-cycle ack after a fixed read latency.
// Optional per-byte write lanes via MEM_RESPONDER_BYTE_ENABLE_EN.
module mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int READ_LATENCY = 2,
  parameter INIT_FILE = ""
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
`ifdef MEM_RESPONDER_BYTE_ENABLE_EN
  input  logic [3:0]  byte_en,
`endif
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_DONE} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [AW-1:0] idx, idx_n;
  logic [31:0] rdata_n;
  logic ack_n, err_n, take, aligned, we;
  logic [3:0] be;
  logic [31:0] mem [DEPTH_WORDS];
  logic unused_hi;
  assign unused_hi = ^addr[31:AW+2];
`ifdef MEM_RESPONDER_BYTE_ENABLE_EN
  assign be = byte_en;
`else
  assign be = 4'hf;
`endif
  assign busy = state != IDLE;
  assign take = state == IDLE && req;
  assign aligned = addr[1:0] == 2'b00;
  // Writes commit at the sampling edge so any later read sees them.
  assign we = take && wr && aligned && reset;
  always_ff @(posedge clock)
    if (we)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[addr[AW+1:2]][8*b +: 8] <= wdata[8*b +: 8];
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    idx_n = idx;
    rdata_n = rdata;
    ack_n = 1'b0;
    err_n = 1'b0;
    if (take && !aligned) begin
      ack_n = 1'b1;
      err_n = 1'b1;
    end else if (take && wr) begin
      state_n = WR_DONE;
    end else if (take) begin
      state_n = RD_WAIT;
      cnt_n = 4'(READ_LATENCY - 1);
      idx_n = addr[AW+1:2];
    end else if (state == WR_DONE) begin
      state_n = IDLE;
      ack_n = 1'b1;
    end else if (state == RD_WAIT) begin
      state_n = cnt == 4'd0 ? IDLE : RD_WAIT;
      ack_n = cnt == 4'd0;
      rdata_n = cnt == 4'd0 ? mem[idx] : rdata;
      cnt_n = cnt == 4'd0 ? cnt : cnt - 4'd1;
    end
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      rdata <= '0;
      ack <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      rdata <= rdata_n;
      ack <= ack_n;
      err <= err_n;
    end
endmodule
